// File: rtl/mem_pkg.sv
// Shared types and defaults for the main-memory responder: port owner encoding,
// the response entry carried through the read pipeline, and the grant-to-owner mapping.
package mem_pkg;

    localparam int MEM_LATENCY        = 4;
    localparam int MEM_WORDS_LOG2_DEF = 15;
    localparam int MEM_DATA_W         = 16;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    typedef struct packed {
        logic                  valid;
        owner_t                tag;
        logic [MEM_DATA_W-1:0] data;
    } resp_t;

    function automatic owner_t grant_owner(input logic grant_i, input logic grant_d);
        owner_t own;
        if (grant_i) begin
            own = OWN_I;
        end else if (grant_d) begin
            own = OWN_D;
        end else begin
            own = OWN_NONE;
        end
        return own;
    endfunction

endpackage

// File: rtl/mem_resp_pipe.sv
// Fixed-depth response delay line. Valid and tag advance every cycle; data only
// advances alongside a valid entry, so the tail keeps the last returned word.
module mem_resp_pipe
    import mem_pkg::*;
#(
    parameter int DEPTH = MEM_LATENCY
) (
    input  logic  clk,
    input  logic  rst_n,
    input  resp_t in_resp,
    output resp_t out_resp
);

    resp_t stage_r [DEPTH];

    // Shift entries one stage per cycle; reset empties every stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_r[i] <= '0;
            end
        end else begin
            stage_r[0].valid <= in_resp.valid;
            stage_r[0].tag   <= in_resp.tag;
            if (in_resp.valid) begin
                stage_r[0].data <= in_resp.data;
            end
            for (int i = 1; i < DEPTH; i++) begin
                stage_r[i].valid <= stage_r[i-1].valid;
                stage_r[i].tag   <= stage_r[i-1].tag;
                if (stage_r[i-1].valid) begin
                    stage_r[i].data <= stage_r[i-1].data;
                end
            end
        end
    end

    assign out_resp = stage_r[DEPTH-1];

endmodule

// File: rtl/mem_responder.sv
// Main-memory responder: arbitrates I/D cache requests with D burst locking,
// serves them from one word array and returns tagged read data after a fixed latency.
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = MEM_DATA_W,
    parameter int MEM_WORDS_LOG2 = MEM_WORDS_LOG2_DEF,
    parameter int LATENCY        = MEM_LATENCY
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req_en,
    input  logic [ADDR_W-1:0] i_req_addr,
    output logic              i_req_ready,
    output logic              i_data_valid,
    input  logic              d_req_en,
    input  logic              d_req_wr,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [DATA_W-1:0] d_req_wdata,
    output logic              d_req_ready,
    output logic              d_data_valid,
    output logic [DATA_W-1:0] data_out
);

    localparam int MEM_WORDS = 1 << MEM_WORDS_LOG2;

    owner_t                    owner_r;
    logic                      grant_i_s;
    logic                      grant_d_s;
    logic                      rd_en_s;
    logic                      wr_en_s;
    logic [MEM_WORDS_LOG2-1:0] i_idx_s;
    logic [MEM_WORDS_LOG2-1:0] d_idx_s;
    logic [MEM_WORDS_LOG2-1:0] rd_idx_s;
    logic [DATA_W-1:0]         mem_r [MEM_WORDS];
    resp_t                     entry_r;
    resp_t                     tail_s;
    logic                      unused_addr_s;

    // Byte-address bit 0 carries no information for a word array.
    assign unused_addr_s = i_req_addr[0] ^ d_req_addr[0];

    assign i_idx_s = i_req_addr[MEM_WORDS_LOG2:1];
    assign d_idx_s = d_req_addr[MEM_WORDS_LOG2:1];

    // Grant: a D owner holding en keeps the port; otherwise I has priority over D.
    always_comb begin
        grant_i_s = 1'b0;
        grant_d_s = 1'b0;
        if ((owner_r == OWN_D) && d_req_en) begin
            grant_d_s = 1'b1;
        end else if (i_req_en) begin
            grant_i_s = 1'b1;
        end else if (d_req_en) begin
            grant_d_s = 1'b1;
        end else begin
            grant_i_s = 1'b0;
            grant_d_s = 1'b0;
        end
    end

    assign i_req_ready = grant_i_s;
    assign d_req_ready = grant_d_s;
    assign wr_en_s     = grant_d_s & d_req_wr;
    assign rd_en_s     = grant_i_s | (grant_d_s & ~d_req_wr);
    assign rd_idx_s    = grant_d_s ? d_idx_s : i_idx_s;

    // Owner follows this cycle's grant; no grant releases the port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_r <= OWN_NONE;
        end else begin
            owner_r <= grant_owner(grant_i_s, grant_d_s);
        end
    end

    // Word array write port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[d_idx_s] <= d_req_wdata;
        end
    end

    // Synchronous array read captured with its owner tag at the accepting edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_r <= '0;
        end else begin
            entry_r.valid <= rd_en_s;
            entry_r.tag   <= grant_owner(grant_i_s, grant_d_s);
            if (rd_en_s) begin
                entry_r.data <= mem_r[rd_idx_s];
            end
        end
    end

    mem_resp_pipe #(
        .DEPTH (LATENCY)
    ) u_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_resp  (entry_r),
        .out_resp (tail_s)
    );

    assign i_data_valid = tail_s.valid && (tail_s.tag == OWN_I);
    assign d_data_valid = tail_s.valid && (tail_s.tag == OWN_D);
    assign data_out     = tail_s.data;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus random traffic
// compared every cycle against a transaction-level model (owner lock flag, word map, response queue).
module tb_mem_responder;

    localparam int L = 4;

    logic        clk;
    logic        rst_n;
    logic        i_req_en;
    logic [15:0] i_req_addr;
    logic        i_req_ready;
    logic        i_data_valid;
    logic        d_req_en;
    logic        d_req_wr;
    logic [15:0] d_req_addr;
    logic [15:0] d_req_wdata;
    logic        d_req_ready;
    logic        d_data_valid;
    logic [15:0] data_out;

    mem_responder #(
        .ADDR_W         (16),
        .DATA_W         (16),
        .MEM_WORDS_LOG2 (15),
        .LATENCY        (L)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_req_en     (i_req_en),
        .i_req_addr   (i_req_addr),
        .i_req_ready  (i_req_ready),
        .i_data_valid (i_data_valid),
        .d_req_en     (d_req_en),
        .d_req_wr     (d_req_wr),
        .d_req_addr   (d_req_addr),
        .d_req_wdata  (d_req_wdata),
        .d_req_ready  (d_req_ready),
        .d_data_valid (d_data_valid),
        .data_out     (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          due;
        bit          is_d;
        logic [15:0] data;
    } exp_t;

    exp_t        rq[$];
    logic [15:0] mem_m [int];
    bit          d_locked_m;
    logic [15:0] last_data;
    int          cyc;
    int          checks;
    int          failures;
    int          i_pulses;
    int          d_pulses;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, exp);
        end
    endtask

    // One clock cycle: compare outputs at the falling edge, then advance the model past the rising edge.
    task automatic cycle();
        bit          gi;
        bit          gd;
        bit          ev_i;
        bit          ev_d;
        logic [15:0] ev_data;
        exp_t        e;
        @(negedge clk);
        if (i_data_valid) i_pulses++;
        if (d_data_valid) d_pulses++;
        if (!rst_n) begin
            chk("reset_i_valid", i_data_valid, 32'd0);
            chk("reset_d_valid", d_data_valid, 32'd0);
            chk("reset_data_out", data_out, 32'd0);
            chk("reset_i_ready", i_req_ready, i_req_en);
            chk("reset_d_ready", d_req_ready, d_req_en & ~i_req_en);
            rq.delete();
            d_locked_m = 1'b0;
            last_data  = 16'h0000;
        end else begin
            ev_i    = 1'b0;
            ev_d    = 1'b0;
            ev_data = last_data;
            if (rq.size() > 0 && rq[0].due == cyc) begin
                e         = rq.pop_front();
                ev_i      = !e.is_d;
                ev_d      = e.is_d;
                ev_data   = e.data;
                last_data = e.data;
            end
            chk("i_data_valid", i_data_valid, ev_i);
            chk("d_data_valid", d_data_valid, ev_d);
            chk("data_out", data_out, ev_data);
            gi = i_req_en && !(d_locked_m && d_req_en);
            gd = d_req_en && !gi;
            chk("i_req_ready", i_req_ready, gi);
            chk("d_req_ready", d_req_ready, gd);
            if (gi) begin
                e.due  = cyc + 1 + L;
                e.is_d = 1'b0;
                e.data = mem_m[int'(i_req_addr[15:1])];
                rq.push_back(e);
            end else if (gd && d_req_wr) begin
                mem_m[int'(d_req_addr[15:1])] = d_req_wdata;
            end else if (gd) begin
                e.due  = cyc + 1 + L;
                e.is_d = 1'b1;
                e.data = mem_m[int'(d_req_addr[15:1])];
                rq.push_back(e);
            end
            d_locked_m = gd;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        i_req_en = 1'b0;
        d_req_en = 1'b0;
        d_req_wr = 1'b0;
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic d_write(input logic [15:0] addr, input logic [15:0] data);
        d_req_en    = 1'b1;
        d_req_wr    = 1'b1;
        d_req_addr  = addr;
        d_req_wdata = data;
        cycle();
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        cyc        = 0;
        d_locked_m = 1'b0;
        last_data  = 16'h0000;
        rst_n       = 1'b0;
        i_req_en    = 1'b0;
        i_req_addr  = 16'h0000;
        d_req_en    = 1'b0;
        d_req_wr    = 1'b0;
        d_req_addr  = 16'h0000;
        d_req_wdata = 16'h0000;
        #1;
        chk("por_i_valid", i_data_valid, 32'd0);
        chk("por_d_valid", d_data_valid, 32'd0);
        chk("por_data_out", data_out, 32'h0000);
        d_req_en = 1'b1;
        cycle();
        d_req_en = 1'b0;
        cycle();
        rst_n = 1'b1;
        idle(2);

        // Preload: single-read word, burst words, random pool.
        d_write(16'h0020, 16'hBEEF);
        for (int n = 0; n < 8; n++) d_write(16'h0100 + 16'(2 * n), 16'h1000 + 16'(n));
        for (int n = 0; n < 16; n++) d_write(16'h0200 + 16'(2 * n), 16'($urandom));
        idle(2);

        // Single read, exact latency.
        i_req_en   = 1'b1;
        i_req_addr = 16'h0020;
        #1;
        chk("single_ready", {31'd0, i_req_ready}, 32'd1);
        cycle();
        i_req_en = 1'b0;
        for (int k = 0; k < 3; k++) cycle();
        chk("single_early", {31'd0, i_data_valid}, 32'd0);
        cycle();
        chk("single_valid", {31'd0, i_data_valid}, 32'd1);
        chk("single_data", {16'd0, data_out}, 32'h0000BEEF);
        chk("single_d_valid", {31'd0, d_data_valid}, 32'd0);
        idle(3);

        // I burst of 8.
        i_pulses = 0;
        i_req_en = 1'b1;
        for (int n = 0; n < 8; n++) begin
            i_req_addr = 16'h0100 + 16'(2 * n);
            cycle();
        end
        idle(6);
        chk("burst_pulses", i_pulses, 32'd8);

        // Write then read of the same word on the next edge.
        d_pulses = 0;
        d_write(16'h0040, 16'h1234);
        d_req_wr = 1'b0;
        cycle();
        d_req_en = 1'b0;
        for (int k = 0; k < 3; k++) cycle();
        chk("wr_no_valid", {31'd0, d_data_valid}, 32'd0);
        cycle();
        chk("rd_after_wr_valid", {31'd0, d_data_valid}, 32'd1);
        chk("rd_after_wr_data", {16'd0, data_out}, 32'h00001234);
        idle(3);
        chk("wr_rd_pulses", d_pulses, 32'd1);

        // Contention from NONE, then D lock, then handoff to I in the same cycle.
        i_req_en   = 1'b1;
        i_req_addr = 16'h0202;
        d_req_en   = 1'b1;
        d_req_wr   = 1'b0;
        d_req_addr = 16'h0204;
        #1;
        chk("contend_i_ready", {31'd0, i_req_ready}, 32'd1);
        chk("contend_d_ready", {31'd0, d_req_ready}, 32'd0);
        cycle();
        i_req_en = 1'b0;
        cycle();
        i_req_en = 1'b1;
        #1;
        chk("lock_d_ready", {31'd0, d_req_ready}, 32'd1);
        chk("lock_i_ready", {31'd0, i_req_ready}, 32'd0);
        cycle();
        cycle();
        d_req_en = 1'b0;
        #1;
        chk("release_i_ready", {31'd0, i_req_ready}, 32'd1);
        cycle();
        idle(6);

        // Handoff: 3 D reads then 3 I reads back to back.
        i_pulses = 0;
        d_pulses = 0;
        d_req_en = 1'b1;
        d_req_wr = 1'b0;
        for (int n = 0; n < 3; n++) begin
            d_req_addr = 16'h0200 + 16'(2 * n);
            cycle();
        end
        d_req_en = 1'b0;
        i_req_en = 1'b1;
        for (int n = 0; n < 3; n++) begin
            i_req_addr = 16'h0210 + 16'(2 * n);
            cycle();
        end
        idle(6);
        chk("handoff_d_pulses", d_pulses, 32'd3);
        chk("handoff_i_pulses", i_pulses, 32'd3);

        // Reset after 2 of 8 burst reads are accepted.
        i_pulses = 0;
        i_req_en = 1'b1;
        for (int n = 0; n < 2; n++) begin
            i_req_addr = 16'h0100 + 16'(2 * n);
            cycle();
        end
        rst_n    = 1'b0;
        i_req_en = 1'b0;
        cycle();
        rst_n = 1'b1;
        idle(6);
        chk("reset_burst_pulses", i_pulses, 32'd0);
        i_req_en   = 1'b1;
        i_req_addr = 16'h0020;
        cycle();
        i_req_en = 1'b0;
        for (int k = 0; k < 3; k++) cycle();
        chk("fresh_early", {31'd0, i_data_valid}, 32'd0);
        cycle();
        chk("fresh_valid", {31'd0, i_data_valid}, 32'd1);
        chk("fresh_data", {16'd0, data_out}, 32'h0000BEEF);
        idle(3);

        // Random traffic with sticky enables over the preloaded pool; bit 0 randomised.
        for (int k = 0; k < 600; k++) begin
            if (i_req_en) i_req_en = ($urandom_range(0, 3) != 0);
            else          i_req_en = ($urandom_range(0, 4) < 2);
            if (d_req_en) d_req_en = ($urandom_range(0, 3) != 0);
            else          d_req_en = ($urandom_range(0, 4) < 2);
            d_req_wr    = ($urandom_range(0, 2) == 0);
            i_req_addr  = 16'h0200 + 16'($urandom_range(0, 31));
            d_req_addr  = 16'h0200 + 16'($urandom_range(0, 31));
            d_req_wdata = 16'($urandom);
            cycle();
        end
        idle(L + 4);
        chk("queue_drained", rq.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
